// File: rtl/imem_loader.sv
// Boot loader: holds the ARM core in reset, writes a framed byte stream into instruction memory,
// verifies the XOR checksum and releases the core. Optional inter-byte timeout via IMEM_LOADER_TIMEOUT_EN.
module imem_loader #(
   parameter int ADDR_W      = 6,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              loading,
   output logic              done,
   output logic [1:0]        err
);

   typedef enum logic [2:0] {LEN0, LEN1, DATA, CHK, RUN, ERR} state_t;

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

   state_t            state, state_next;
   logic [1:0]        err_next;
   logic [15:0]       len;
   logic [7:0]        csum;
   logic [1:0]        byte_idx;
   logic [ADDR_W:0]   word_cnt;
   logic [31:0]       word_buf;
   logic              accept;
   logic              reload_take;
   logic              timeout;
   logic [15:0]       len_full;
   logic              last_byte;
   logic              last_word;

   assign accept      = rx_valid && rx_ready;
   assign reload_take = reload && (state == RUN || state == ERR);
   assign len_full    = {rx_data, len[7:0]};
   assign last_byte   = (byte_idx == 2'd3);
   // word_cnt is one bit wider than the address so a full-depth frame never wraps
   assign last_word   = ({{(15 - ADDR_W){1'b0}}, word_cnt} == (len - 16'd1));

`ifdef IMEM_LOADER_TIMEOUT_EN
   logic [31:0] idle_cnt;
   logic        waiting;

   assign waiting = (state == LEN1 || state == DATA || state == CHK);
   assign timeout = waiting && !accept && (idle_cnt == 32'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (reset || !waiting || accept || state_next != state) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + 32'd1;
      end
   end
`else
   logic unused_timeout;

   assign timeout        = 1'b0;
   assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

   always_comb begin
      state_next = state;
      err_next   = err;
      case (state)
         LEN0: begin
            if (accept) state_next = LEN1;
         end
         LEN1: begin
            if (accept) begin
               if ({1'b0, len_full} > DEPTH) begin
                  state_next = ERR;
                  err_next   = 2'b01;
               end else if (len_full == 16'd0) begin
                  state_next = CHK;
               end else begin
                  state_next = DATA;
               end
            end else if (timeout) begin
               state_next = ERR;
               err_next   = 2'b11;
            end
         end
         DATA: begin
            if (accept && last_byte && last_word) begin
               state_next = CHK;
            end else if (timeout) begin
               state_next = ERR;
               err_next   = 2'b11;
            end
         end
         CHK: begin
            if (accept) begin
               if (rx_data == csum) begin
                  state_next = RUN;
               end else begin
                  state_next = ERR;
                  err_next   = 2'b10;
               end
            end else if (timeout) begin
               state_next = ERR;
               err_next   = 2'b11;
            end
         end
         RUN, ERR: begin
            if (reload_take) begin
               state_next = LEN0;
               err_next   = 2'b00;
            end
         end
         default: begin
            state_next = LEN0;
            err_next   = 2'b00;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they change on the same edge as the state
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= LEN0;
         err        <= 2'b00;
         rx_ready   <= 1'b1;
         loading    <= 1'b1;
         cpu_reset  <= 1'b1;
         done       <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         len        <= '0;
         csum       <= '0;
         byte_idx   <= '0;
         word_cnt   <= '0;
         word_buf   <= '0;
      end else begin
         state     <= state_next;
         err       <= err_next;
         rx_ready  <= (state_next inside {LEN0, LEN1, DATA, CHK});
         loading   <= (state_next inside {LEN0, LEN1, DATA, CHK});
         cpu_reset <= (state_next != RUN);
         done      <= (state_next == RUN);
         imem_we   <= 1'b0;
         if (reload_take) begin
            len      <= '0;
            csum     <= '0;
            byte_idx <= '0;
            word_cnt <= '0;
         end else if (accept) begin
            case (state)
               LEN0: len[7:0]  <= rx_data;
               LEN1: len[15:8] <= rx_data;
               DATA: begin
                  csum     <= csum ^ rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  word_buf <= {rx_data, word_buf[31:8]};
                  if (last_byte) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= word_cnt[ADDR_W-1:0];
                     imem_wdata <= {rx_data, word_buf[31:8]};
                     word_cnt   <= word_cnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: framing, checksum, length limit, reload,
// mid-frame reset, full-depth frame and (when IMEM_LOADER_TIMEOUT_EN is defined) the inter-byte timeout.
module tb_imem_loader;

   logic        clk;
   logic        reset;
   logic        rxValid;
   logic [7:0]  rxData;
   logic        rxReady;
   logic        reload;
   logic        imemWe;
   logic [5:0]  imemAddr;
   logic [31:0] imemWdata;
   logic        cpuReset;
   logic        loading;
   logic        done;
   logic [1:0]  err;

   int          checkCount = 0;
   int          errorCount = 0;
   int          wrCount = 0;
   logic [5:0]  wrAddr [0:255];
   logic [31:0] wrData [0:255];
   int          wrBase;

   imem_loader #(.ADDR_W(6), .TIMEOUT_CYC(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rxValid),
      .rx_data    (rxData),
      .rx_ready   (rxReady),
      .reload     (reload),
      .imem_we    (imemWe),
      .imem_addr  (imemAddr),
      .imem_wdata (imemWdata),
      .cpu_reset  (cpuReset),
      .loading    (loading),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Log every write strobe so each test can inspect the writes it caused
   always @(negedge clk) begin
      if (imemWe && wrCount < 256) begin
         wrAddr[wrCount] = imemAddr;
         wrData[wrCount] = imemWdata;
         wrCount = wrCount + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Present one byte and hold it until accepted; called and returns at a falling edge
   task automatic applyStimulus(input logic [7:0] value, input int gap);
      logic seen;
      logic taken;
      taken   = 1'b0;
      rxData  = value;
      rxValid = 1'b1;
      for (int i = 0; i < 50 && !taken; i++) begin
         seen = rxReady;
         @(posedge clk);
         @(negedge clk);
         taken = seen;
      end
      rxValid = 1'b0;
      if (!taken) checkOutput("byteAccept", 32'd0, 32'd1);
      repeat (gap) @(negedge clk);
   endtask

   task automatic pulseReload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic sendFrame(input logic [7:0] bytes [], input int gap);
      foreach (bytes[i]) applyStimulus(bytes[i], gap);
   endtask

   initial begin
      reset   = 1'b1;
      rxValid = 1'b0;
      rxData  = 8'h00;
      reload  = 1'b0;
      repeat (2) @(negedge clk);

      checkOutput("rstCpuReset", 32'(cpuReset), 32'd1);
      checkOutput("rstRxReady", 32'(rxReady), 32'd1);
      checkOutput("rstLoading", 32'(loading), 32'd1);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstErr", 32'(err), 32'd0);
      checkOutput("rstWe", 32'(imemWe), 32'd0);
      checkOutput("rstAddr", 32'(imemAddr), 32'd0);
      checkOutput("rstWdata", imemWdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single word frame
      wrBase = wrCount;
      sendFrame('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 0);
      checkOutput("t1CpuResetBeforeChk", 32'(cpuReset), 32'd1);
      applyStimulus(8'h08, 0);
      checkOutput("t1CpuResetFall", 32'(cpuReset), 32'd0);
      checkOutput("t1Done", 32'(done), 32'd1);
      checkOutput("t1Err", 32'(err), 32'd0);
      checkOutput("t1RxReady", 32'(rxReady), 32'd0);
      checkOutput("t1Loading", 32'(loading), 32'd0);
      checkOutput("t1WrCount", 32'(wrCount - wrBase), 32'd1);
      checkOutput("t1Addr", 32'(wrAddr[wrBase]), 32'd0);
      checkOutput("t1Data", wrData[wrBase], 32'h12345678);

      // Reload then two words with rx_valid toggling
      pulseReload();
      checkOutput("t2ReloadLoading", 32'(loading), 32'd1);
      checkOutput("t2ReloadCpuReset", 32'(cpuReset), 32'd1);
      checkOutput("t2ReloadDone", 32'(done), 32'd0);
      wrBase = wrCount;
      sendFrame('{8'h02, 8'h00, 8'h05, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h80, 8'hE2, 8'h35}, 1);
      checkOutput("t2Done", 32'(done), 32'd1);
      checkOutput("t2WrCount", 32'(wrCount - wrBase), 32'd2);
      checkOutput("t2Addr0", 32'(wrAddr[wrBase]), 32'd0);
      checkOutput("t2Data0", wrData[wrBase], 32'hE3A00005);
      checkOutput("t2Addr1", 32'(wrAddr[wrBase + 1]), 32'd1);
      checkOutput("t2Data1", wrData[wrBase + 1], 32'hE2801001);

      // Checksum 00 accepted, then 0xFF rejected
      pulseReload();
      wrBase = wrCount;
      sendFrame('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}, 0);
      checkOutput("t3GoodDone", 32'(done), 32'd1);
      checkOutput("t3GoodData", wrData[wrBase], 32'hDDCCBBAA);
      pulseReload();
      sendFrame('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF}, 0);
      checkOutput("t3BadErr", 32'(err), 32'd2);
      checkOutput("t3BadCpuReset", 32'(cpuReset), 32'd1);
      checkOutput("t3BadRxReady", 32'(rxReady), 32'd0);
      checkOutput("t3BadDone", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("t3ErrHold", 32'(err), 32'd2);

      // Length overflow: N = 65 > 64
      pulseReload();
      checkOutput("t4ReloadErrClear", 32'(err), 32'd0);
      wrBase = wrCount;
      sendFrame('{8'h41, 8'h00}, 0);
      checkOutput("t4LenErr", 32'(err), 32'd1);
      checkOutput("t4LenLoading", 32'(loading), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("t4LenNoWrite", 32'(wrCount - wrBase), 32'd0);
      pulseReload();
      checkOutput("t4ReloadErr", 32'(err), 32'd0);
      checkOutput("t4ReloadLoading", 32'(loading), 32'd1);
      sendFrame('{8'h00, 8'h00, 8'h00}, 0);
      checkOutput("t4EmptyDone", 32'(done), 32'd1);
      checkOutput("t4EmptyErr", 32'(err), 32'd0);

      // Full depth: N = 64, bytes 0..255, checksum of all is 0
      pulseReload();
      wrBase = wrCount;
      applyStimulus(8'h40, 0);
      applyStimulus(8'h00, 0);
      for (int j = 0; j < 256; j++) applyStimulus(8'(j), 0);
      checkOutput("t5CpuResetBeforeChk", 32'(cpuReset), 32'd1);
      applyStimulus(8'h00, 0);
      checkOutput("t5Done", 32'(done), 32'd1);
      checkOutput("t5WrCount", 32'(wrCount - wrBase), 32'd64);
      checkOutput("t5FirstAddr", 32'(wrAddr[wrBase]), 32'd0);
      checkOutput("t5FirstData", wrData[wrBase], 32'h03020100);
      checkOutput("t5LastAddr", 32'(wrAddr[wrBase + 63]), 32'd63);
      checkOutput("t5LastData", wrData[wrBase + 63], 32'hFFFEFDFC);

      // Reset in the middle of the first word
      pulseReload();
      wrBase = wrCount;
      sendFrame('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33}, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("t6NoWrite", 32'(wrCount - wrBase), 32'd0);
      checkOutput("t6Loading", 32'(loading), 32'd1);
      checkOutput("t6CpuReset", 32'(cpuReset), 32'd1);
      sendFrame('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08}, 0);
      checkOutput("t6FreshDone", 32'(done), 32'd1);
      checkOutput("t6FreshCount", 32'(wrCount - wrBase), 32'd1);
      checkOutput("t6FreshData", wrData[wrBase], 32'h12345678);

      // Stall after the low length byte
      pulseReload();
      applyStimulus(8'h05, 0);
`ifdef IMEM_LOADER_TIMEOUT_EN
      repeat (15) @(negedge clk);
      checkOutput("t7NoEarlyTimeout", 32'(err), 32'd0);
      @(negedge clk);
      checkOutput("t7TimeoutErr", 32'(err), 32'd3);
      checkOutput("t7TimeoutCpuReset", 32'(cpuReset), 32'd1);
`else
      repeat (1000) @(negedge clk);
      checkOutput("t7StillLoading", 32'(loading), 32'd1);
      checkOutput("t7NoErr", 32'(err), 32'd0);
      checkOutput("t7StillReady", 32'(rxReady), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time sequencer that owns the ARM core's reset and instruction-memory write port.
- Holds the core in reset and receives a framed byte stream over a valid/ready interface. Assembles little-endian 32-bit words and writes them sequentially into instruction memory from word address 0.
- Verifies an XOR checksum, then releases the core to fetch from PC=0.
- Sits between the host byte receiver (UART RX) and the arm top plus instruction memory.

Parameters:
- ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words.
- TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles; used only with IMEM_LOADER_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- rx_valid  input  1  byte available
- rx_data  input  8  byte value
- rx_ready  output  1  loader accepts byte this cycle
- reload  input  1  one-cycle pulse: re-enter load mode
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  32  write data
- cpu_reset  output  1  drives arm reset; high = core held
- loading  output  1  high in LEN0/LEN1/DATA/CHK
- done  output  1  high in RUN
- err  output  2  00 none, 01 length overflow, 10 checksum mismatch, 11 timeout

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - State = LEN0.
  - cpu_reset=1, rx_ready=1, loading=1.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - done=0, err=00.
  - Checksum=0, byte index=0, word count=0.
- Accept rule: a byte is consumed on a cycle where rx_valid && rx_ready. rx_valid without rx_ready is ignored; the byte must be held by the source.
- Frame format: N[7:0], N[15:8], then N×4 data bytes (LSB first per word), then 1 checksum byte. The checksum is the XOR of all data bytes only.
- States:
  - LEN0: accept the byte into N[7:0] → LEN1.
  - LEN1: accept the byte into N[15:8].
    - If N > 2^ADDR_W → ERR with err=01.
    - Else if N == 0 → CHK.
    - Else → DATA.
  - DATA:
    - Shift bytes into the word assembler and XOR each into the checksum.
    - On the 4th byte of a word, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = the assembled word. The word index then increments.
    - After word N-1 is accepted → CHK. This is a back-to-back transition; DATA never stalls, and rx_ready stays 1.
  - CHK: accept the byte.
    - If it equals the running checksum → RUN.
    - Else → ERR with err=10.
  - RUN: rx_ready=0, cpu_reset=0, done=1, loading=0. cpu_reset falls on the first cycle in RUN.
  - ERR: rx_ready=0, cpu_reset=1, done=0, loading=0. err holds until reset or reload.
- Last-write ordering: the final imem_we pulse occurs no later than the CHK accept cycle, so it always completes before cpu_reset falls.
- reload: honoured only in RUN or ERR.
  - Next cycle: state = LEN0, cpu_reset=1, rx_ready=1, err=00, checksum/indices cleared.
  - Ignored in every other state.
- Simultaneous events: reset overrides reload and any accept in the same cycle.
- Mid-frame reset: an in-flight frame is discarded; no partial imem_we is issued after reset.
- Address wrap: N = 2^ADDR_W is legal. The final write is to address 2^ADDR_W-1, and the index never wraps to 0 during a frame.

Optional Feature:
- IMEM_LOADER_TIMEOUT_EN
- Defined:
  - An idle counter runs in LEN1, DATA and CHK. It clears on every accepted byte and on state entry.
  - When the count reaches TIMEOUT_CYC-1 without an accept → ERR with err=11 on the following cycle.
  - LEN0 never times out.
- Undefined: no counter is instantiated; err code 11 is unreachable; the loader waits indefinitely.

Test Plan:
- Reset, then send 01 00 78 56 34 12 08 (checksum 0x78^0x56^0x34^0x12=0x08) → one imem_we with addr 0, wdata 0x12345678; cpu_reset falls the cycle after the checksum accept; done=1, err=00.
- Send N=2 with words 0xE3A00005, 0xE2801001 and the correct checksum, with rx_valid toggling every other cycle → writes at addr 0 then 1 with the exact words; no byte is lost or duplicated while rx_ready=1.
- Send 01 00 AA BB CC DD 00 (correct checksum 0x00) followed by a wrong-checksum variant using 0xFF → first: done=1; second: err=10, cpu_reset stays 1, rx_ready=0.
- With ADDR_W=6, send N=0x0041 → ERR with err=01 immediately after the LEN1 accept, with zero imem_we pulses. Then a reload pulse → LEN0, err=00; a subsequent N=0 with checksum 00 → RUN.
- Assert reset after 3 data bytes of the first word → no imem_we; state LEN0; cpu_reset=1; a fresh frame then loads correctly.
- With IMEM_LOADER_TIMEOUT_EN defined and TIMEOUT_CYC=16, stop after LEN0 → err=11 after 16 idle cycles. Without the macro, the same stimulus stays in LEN1 for 1000 cycles.
